uart_tx_module: RTL and testbench
=================================

# uart_tx_module

Serial UART transmitter, 8N1 framing, LSB first, fixed baud set by a clock-divider parameter. Sits on the transmit side of the serial link and accepts one byte at a time from the system through a valid/ready handshake. It drives the idle-high TX pin. It is the transmit counterpart of the receive path's start-bit detector and sampler, and it uses the same clock and reset.

## Interface
- CLKS_PER_BIT, default 5208 (50 MHz / 9600 baud): clock cycles per serial bit. Legal range is ≥ 2. Counter width is clog2(CLKS_PER_BIT).
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled only on an accepted handshake.
- tx_en  input  1  request/valid; a byte is accepted when tx_en and tx_rdy are both 1 at a rising edge.
- tx_rdy  output  1  1 = idle and able to accept a byte.
- tx_pin_out  output  1  serial line, registered, idle high.
- tx_done_sig  output  1  single-cycle pulse when a frame's stop bit completes.

## Operation
- Reset values (asynchronous, take effect immediately, including mid-frame): tx_pin_out=1, tx_rdy=1, tx_done_sig=0, state=IDLE, bit counter=0, clock counter=0, shift register=0.
- FSM states and transitions:
  - IDLE: tx_pin_out=1, tx_rdy=1. An accepted handshake latches tx_data into the shift register, clears the clock counter, and goes to START.
  - START: tx_pin_out=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx_pin_out=shift[index] for CLKS_PER_BIT cycles per bit. Bit index runs 0..7. After bit 7, go to STOP.
  - STOP: tx_pin_out=1 for CLKS_PER_BIT cycles, then IDLE. On that transition, assert tx_done_sig for one cycle.
- Clock counter: counts 0..CLKS_PER_BIT-1. It wraps to 0 at each bit boundary. It never exceeds CLKS_PER_BIT-1.
- tx_en with tx_rdy=0 is ignored. No queueing. The shift register is not disturbed.
- tx_data may change freely while tx_rdy=0; the byte in flight is unaffected.
- tx_en held continuously high makes frames back-to-back with the minimum gap defined below.
- No parity, one stop bit, no break generation.

## Timing
- Let N=CLKS_PER_BIT and let edge k be the rising edge where tx_en & tx_rdy is sampled 1.
- At edge k: tx_rdy→0 and tx_pin_out→0. The start bit occupies edges k .. k+N.
- Data bit i (i=0..7) is driven from edge k+(1+i)·N to k+(2+i)·N.
- The stop bit is driven from edge k+9N.
- At edge k+10N: state→IDLE, tx_rdy→1, tx_done_sig→1. At edge k+10N+1: tx_done_sig→0.
- Earliest next accept is edge k+10N+1. The minimum stop/idle high time between frames is therefore N+1 cycles, and the frame period is 10N+1 cycles.
- Latency from accept to the line's falling edge is 1 cycle, because the output is registered.
- The output is glitch-free: tx_pin_out changes only at bit boundaries.
- Reset asserted mid-frame forces the line high the same instant, with no partial-frame completion and no tx_done_sig. After rstn deasserts, the first accept is possible at the first rising edge.

## Test plan
- Reset check, N=4: hold rstn=0 with tx_en=1 → tx_pin_out=1, tx_rdy=1, tx_done_sig=0. Release rstn → accept at the first edge with tx_en=1.
- Single byte 0xA5, N=4: the line, sampled mid-bit every 4 cycles from the accept edge, reads 0,1,0,1,0,0,1,0,1,1. tx_done_sig is a 1-cycle pulse exactly 40 cycles after accept. tx_rdy is low for exactly 40 cycles.
- Back-to-back 0x00 then 0xFF with tx_en held high, N=4: the second start bit falls exactly 41 cycles after the first, with the stop-high interval = 5 cycles. Sampled line bits for the second frame are 0,1×8,1.
- tx_en pulses and tx_data changes to 0x3C during a 0x81 frame → the line transmits 0x81 unaltered, no extra frame follows, and exactly one tx_done_sig.
- Reset mid-frame: assert rstn=0 during data bit 3 → tx_pin_out=1 asynchronously, tx_rdy=1, and no tx_done_sig. After release, a fresh 0x5A frame is transmitted correctly.
- Baud check with default N=5208: a frame of 0x55 measures start-bit width = 5208 cycles, and every bit transition lands on a multiple of 5208 from the accept edge.

Source files
------------

// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter, LSB first, with a valid/ready byte handshake.
// The serial line is registered, and it changes only on bit boundaries.
module uart_tx_module #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_rdy,
  output logic       tx_pin_out,
  output logic       tx_done_sig
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             pin_nxt, done_nxt;
  logic             bit_end;

  assign bit_end = (clk_cnt == CNT_LAST);
  assign tx_rdy  = (state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      tx_pin_out  <= 1'b1;
      tx_done_sig <= 1'b0;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift       <= shift_nxt;
      tx_pin_out  <= pin_nxt;
      tx_done_sig <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    done_nxt    = 1'b0;
    pin_nxt     = 1'b1;

    case (state)
      IDLE: begin
        if (tx_en) begin
          shift_nxt   = tx_data;
          clk_cnt_nxt = '0;
          state_nxt   = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is derived from the next state so the pin register leads nothing and lags nothing.
    case (state_nxt)
      START:   pin_nxt = 1'b0;
      DATA:    pin_nxt = shift_nxt[bit_idx_nxt];
      default: pin_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_module.sv
// Scoreboard bench for uart_tx_module: a fast N=4 instance for framing and
// handshake behaviour, plus a default-N instance for the baud-timing check.
module tb_uart_tx_module;

  localparam int N  = 4;
  localparam int NB = 5208;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    int         accept_cyc;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [7:0] tx_data, tx_data_b;
  logic       tx_en, tx_en_b;
  logic       tx_rdy, tx_rdy_b;
  logic       tx_pin_out, tx_pin_out_b;
  logic       tx_done_sig, tx_done_sig_b;

  int   cyc;
  int   assert_count;
  int   fail_count;
  int   done_high;
  int   last_accept;
  exp_t exp_q[$];

  uart_tx_module #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_en(tx_en),
    .tx_rdy(tx_rdy), .tx_pin_out(tx_pin_out), .tx_done_sig(tx_done_sig)
  );

  uart_tx_module dut_b (
    .clk(clk), .rstn(rstn), .tx_data(tx_data_b), .tx_en(tx_en_b),
    .tx_rdy(tx_rdy_b), .tx_pin_out(tx_pin_out_b), .tx_done_sig(tx_done_sig_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial done_high = 0;
  always @(negedge clk) if (tx_done_sig === 1'b1) done_high <= done_high + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Waits for the DUT to be ready, records the expected frame, and leaves tx_en high if hold is set.
  task automatic send_byte(input logic [7:0] b, input logic [9:0] frame, input bit hold);
    int n;
    exp_t e;
    @(negedge clk);
    tx_data = b;
    tx_en   = 1'b1;
    n = 0;
    while (tx_rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx_rdy !== 1'b1) begin
      check("rdy_timeout", 32'(tx_rdy), 32'd1);
      tx_en = 1'b0;
      return;
    end
    e.data = b; e.frame = frame; e.accept_cyc = cyc + 1;
    exp_q.push_back(e);
    last_accept = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) tx_en = 1'b0;
  endtask

  task automatic collect_frame();
    exp_t       e;
    logic [9:0] bits;
    bit         done_ok, rdy_ok, aborted;
    int         start_cyc;
    bits = '0; done_ok = 1; rdy_ok = 1; aborted = 0;
    start_cyc = cyc;
    for (int t = 0; t <= 10 * N; t++) begin
      if (t > 0) @(negedge clk);
      if (rstn !== 1'b1) begin
        aborted = 1;
        break;
      end
      if (t % N == N / 2) bits[t / N] = tx_pin_out;
      if (t < 10 * N) begin
        if (tx_done_sig !== 1'b0) done_ok = 0;
        if (tx_rdy !== 1'b0) rdy_ok = 0;
      end else begin
        if (tx_done_sig !== 1'b1) done_ok = 0;
        if (tx_rdy !== 1'b1) rdy_ok = 0;
      end
    end
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    if (aborted) return;
    check("start_cycle", 32'(start_cyc), 32'(e.accept_cyc));
    check("frame_bits", 32'(bits), 32'(e.frame));
    check("done_timing", 32'(done_ok), 32'd1);
    check("rdy_low_window", 32'(rdy_ok), 32'd1);
  endtask

  initial begin : monitor
    logic prev_pin;
    prev_pin = 1'b1;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && prev_pin === 1'b1 && tx_pin_out === 1'b0) collect_frame();
      prev_pin = tx_pin_out;
    end
  end

  initial begin : stimulus
    int a1, first_change, changes;
    bit aligned;
    logic last_pin;
    assert_count = 0; fail_count = 0; last_accept = 0;
    tx_data = 8'hA5; tx_en = 1'b1;
    tx_data_b = 8'h00; tx_en_b = 1'b0;
    rstn = 1'b1;
    #1 rstn = 1'b0;

    // Reset held with tx_en high: line idle, nothing accepted.
    repeat (3) @(negedge clk);
    check("reset_pin", 32'(tx_pin_out), 32'd1);
    check("reset_rdy", 32'(tx_rdy), 32'd1);
    check("reset_done", 32'(tx_done_sig), 32'd0);

    // Release: the very first edge accepts 0xA5.
    #2 rstn = 1'b1;
    exp_q.push_back('{data: 8'hA5, frame: 10'b1101001010, accept_cyc: cyc + 1});
    @(posedge clk);
    #1 tx_en = 1'b0;
    check("first_edge_accept", 32'(tx_rdy), 32'd0);
    repeat (50) @(negedge clk);

    // Back-to-back 0x00 then 0xFF with tx_en held high.
    send_byte(8'h00, 10'b1000000000, 1'b1);
    a1 = last_accept;
    tx_data = 8'hFF;
    send_byte(8'hFF, 10'b1111111110, 1'b0);
    check("b2b_gap", 32'(last_accept - a1), 32'd41);
    repeat (50) @(negedge clk);

    // 0x81 in flight while tx_en pulses with different data.
    send_byte(8'h81, 10'b1100000010, 1'b0);
    for (int p = 0; p < 3; p++) begin
      repeat (9) @(negedge clk);
      tx_data = 8'h3C; tx_en = 1'b1;
      @(negedge clk);
      tx_en = 1'b0;
    end
    repeat (60) @(negedge clk);

    // Reset during data bit 3 of 0xC3 (line low there).
    send_byte(8'hC3, 10'b1110000110, 1'b0);
    repeat (17) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midreset_pin", 32'(tx_pin_out), 32'd1);
    check("midreset_rdy", 32'(tx_rdy), 32'd1);
    check("midreset_done", 32'(tx_done_sig), 32'd0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    send_byte(8'h5A, 10'b1010110100, 1'b0);
    repeat (60) @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_pulse_cycles", 32'(done_high), 32'd5);

    // Default-baud instance: every transition of 0x55 lands on a multiple of NB.
    @(negedge clk);
    check("baud_rdy", 32'(tx_rdy_b), 32'd1);
    tx_data_b = 8'h55; tx_en_b = 1'b1;
    @(posedge clk);
    #1 tx_en_b = 1'b0;
    @(negedge clk);
    check("baud_start_low", 32'(tx_pin_out_b), 32'd0);
    last_pin = 1'b0; first_change = -1; changes = 0; aligned = 1;
    for (int t = 1; t <= 10 * NB; t++) begin
      @(negedge clk);
      if (tx_pin_out_b !== last_pin) begin
        changes++;
        if (first_change < 0) first_change = t;
        if (t % NB != 0) aligned = 0;
      end
      last_pin = tx_pin_out_b;
      if (t == 10 * NB) check("baud_done", 32'(tx_done_sig_b), 32'd1);
    end
    check("baud_start_width", 32'(first_change), 32'(NB));
    check("baud_transitions", 32'(changes), 32'd9);
    check("baud_aligned", 32'(aligned), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
